nios_button_pio: RTL



---
 rtl/nios_button_pio_pkg.sv | 15 +
 rtl/button_debounce.sv | 58 +++++
 rtl/nios_button_pio.sv | 97 +++++++++
 3 files changed

// File: rtl/nios_button_pio_pkg.sv
// Shared constants and helpers for the nios_button_pio input port.
// Holds the register word offsets and the debounce counter width function.
package nios_button_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Wide enough to hold the value cycles itself; cycles is always >= 1.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Single-bit button conditioner: 2-flop synchroniser, stability counter,
// debounced output and one-clock rise/fall pulses aligned with the deb update.
module button_debounce
  import nios_button_pio_pkg::*;
#(
  parameter int   CYCLES = 50000,
  parameter logic INIT   = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic deb_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int             CW       = cnt_width(CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic          deb_q;
  logic          deb_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any sample equal to deb restarts the count, so bounces never commit.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= INIT;
      sync_q <= INIT;
      deb_q  <= INIT;
      cnt_q  <= '0;
    end else begin
      meta_q <= in_i;
      sync_q <= meta_q;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign deb_o  = deb_q;
  assign rise_o = ~deb_q & deb_d;
  assign fall_o = deb_q & ~deb_d;

endmodule

// File: rtl/nios_button_pio.sv
// Avalon-MM PIO-compatible debounced button/switch input port with edge capture and irq.
// Build option BUTTON_PIO_BOTH_EDGES_EN: capture both deb transitions instead of falls only.
module nios_button_pio
  import nios_button_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] INIT_VALUE      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] cap_evt;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] irqmask_d;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             wr;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    button_debounce #(
      .CYCLES (DEBOUNCE_CYCLES),
      .INIT   (INIT_VALUE[i])
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .in_i    (in_port[i]),
      .deb_o   (deb[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i])
    );
  end

`ifdef BUTTON_PIO_BOTH_EDGES_EN
  assign cap_evt = fall | rise;
`else
  logic unused_rise;
  assign cap_evt     = fall;
  assign unused_rise = &{1'b0, rise};
`endif

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = &{1'b0, writedata};

  // The capture event is OR-ed in after the W1C so a same-edge set survives.
  always_comb begin
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr && address == ADDR_IRQMASK) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr && address == ADDR_EDGECAP) begin
      edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    end
    edgecap_d = edgecap_d | cap_evt;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = deb;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule
